if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch and PC unit that sits directly upstream of the SCPU control decoder.
- Holds the PC and drives it to instruction ROM.
- Captures the returned word into an instruction register (IR) and presents OPcode/Fun to the decoder.
- Computes the next PC from the decoder's Jump/Branch outputs and the ALU zero flag.
- Two-phase fetch/execute FSM, CPI = 2; memory wait via MIO_ready.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] ignored and forced to 0.
- BUBBLE_OP, 6'h3F, opcode presented while no instruction is valid; must decode to all-zero controls.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- MIO_ready  in  1  ROM/bus ready; 1 = inst_in valid this cycle
- inst_in  in  32  instruction word from ROM at PC_out
- Jump  in  1  from decoder, unconditional jump
- Branch  in  1  from decoder, beq
- zero  in  1  ALU zero flag for the current instruction
- PC_out  out  32  current PC, ROM address
- inst_out  out  32  IR contents
- OPcode  out  6  to decoder: IR[31:26] in EXEC, else BUBBLE_OP
- Fun  out  6  to decoder: IR[5:0] in EXEC, else 6'h00
- inst_valid  out  1  1 only in EXEC; datapath gates register/memory writes with it

Behaviour:
- Reset:
  - One clock and a synchronous active-high reset.
  - rst=1 at an edge overrides all else: state<=FETCH, PC<=RESET_PC & ~3, IR<=0.
  - Outputs after reset: PC_out=RESET_PC, inst_out=0, OPcode=BUBBLE_OP, Fun=0, inst_valid=0.
  - Reset in any state, including mid-EXEC, discards the instruction with no PC update.
- FSM states: FETCH, EXEC.
  - FETCH:
    - Outputs bubble.
    - MIO_ready=1 at edge: IR<=inst_in, ->EXEC.
    - MIO_ready=0: IR and PC hold, stay FETCH for any number of cycles.
  - EXEC:
    - OPcode/Fun/inst_out come from IR; inst_valid=1 for exactly one cycle.
    - At the edge: PC<=next_pc, ->FETCH unconditionally. MIO_ready is ignored in EXEC.
- next_pc, computed combinationally from IR and PC; all adds mod 2^32, wrap silently:
  - pc4 = PC+4
  - Jump=1: {pc4[31:28], IR[25:0], 2'b00}. Jump has priority over Branch.
  - else Branch=1 and zero=1: pc4 + (sext(IR[15:0]) << 2)
  - else: pc4
- Invariants:
  - PC[1:0] is always 00.
  - PC_out changes only on an EXEC->FETCH edge or on reset.
- Simultaneous events:
  - Jump=1 and Branch=1 together: jump wins.
  - Branch=1 with zero=0: pc4.
  - Jump/Branch/zero are sampled only in EXEC; they are don't-care in FETCH.

Optional Feature:
- Macro IF_INSTRET_EN.
- Defined:
  - Adds output port instret [31:0], a retired-instruction counter.
  - Reset to 0; +1 on every EXEC->FETCH edge; wraps at 2^32.
  - Reset mid-EXEC does not count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles, RESET_PC=0 -> PC_out=0, OPcode=6'h3F, Fun=0, inst_valid=0.
- Sequential fetch: MIO_ready=1; inst_in=32'h0022_1820 (add) at PC 0 -> cycle 1 EXEC with OPcode=0, Fun=6'h20, inst_valid=1; cycle 2 PC_out=4, FETCH.
- Branches at PC=0x10:
  - IR=32'h1000_0003, Branch=1, zero=1 -> PC=0x20.
  - Same with zero=0 -> PC=0x14.
  - IR imm=16'hFFFF, taken -> PC=0x10.
- Jump: IR=32'h0800_0040 at PC=0x10, Jump=1, Branch=1 -> PC=0x100, jump wins.
- Wait: MIO_ready=0 for 3 FETCH cycles -> PC holds, bubble held, inst_valid=0 throughout; MIO_ready=1 -> EXEC the next cycle.
- Reset mid-EXEC:
  - rst=1 during EXEC at PC=0x40 -> next cycle PC=RESET_PC, FETCH, no PC update.
  - With IF_INSTRET_EN, instret=0.
  - Also verify instret=5 after 5 retired instructions.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: PC and instruction-register unit feeding the SCPU decoder; two-phase FETCH/EXEC, CPI = 2.
// Define IF_INSTRET_EN to add the instret retired-instruction counter output.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [5:0]  BUBBLE_OP = 6'h3F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MIO_ready,
   input  logic [31:0] inst_in,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        zero,
   output logic [31:0] PC_out,
   output logic [31:0] inst_out,
   output logic [5:0]  OPcode,
   output logic [5:0]  Fun,
   output logic        inst_valid
`ifdef IF_INSTRET_EN
   ,
   output logic [31:0] instret
`endif
);

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] pc4;
   logic [31:0] br_off;
   logic [31:0] next_pc_d;
`ifdef IF_INSTRET_EN
   logic [31:0] instret_q;
`endif

   assign pc4    = pc_q + 32'd4;
   assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      next_pc_d = pc4;
      if (Jump) begin
         next_pc_d = {pc4[31:28], ir_q[25:0], 2'b00};
      end else if (Branch && zero) begin
         next_pc_d = pc4 + br_off;
      end
   end

   // NOTE: state is written with non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC & ~32'd3;
         ir_q    <= '0;
`ifdef IF_INSTRET_EN
         instret_q <= '0;
`endif
      end else begin
         case (state_q)
            FETCH: begin
               if (MIO_ready) begin
                  ir_q    <= inst_in;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               // Decoder controls are only meaningful here; MIO_ready is ignored.
               pc_q    <= next_pc_d;
               state_q <= FETCH;
`ifdef IF_INSTRET_EN
               instret_q <= instret_q + 32'd1;
`endif
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   assign inst_valid = (state_q == EXEC);
   assign PC_out     = pc_q;
   assign inst_out   = ir_q;
   assign OPcode     = inst_valid ? ir_q[31:26] : BUBBLE_OP;
   assign Fun        = inst_valid ? ir_q[5:0]   : 6'h00;
`ifdef IF_INSTRET_EN
   assign instret    = instret_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random stimulus against a behavioural model.
module tb_if_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [5:0]  BUBBLE_OP = 6'h3F;

   logic        clk;
   logic        rst;
   logic        MIO_ready;
   logic [31:0] inst_in;
   logic        Jump;
   logic        Branch;
   logic        zero;
   logic [31:0] PC_out;
   logic [31:0] inst_out;
   logic [5:0]  OPcode;
   logic [5:0]  Fun;
   logic        inst_valid;
`ifdef IF_INSTRET_EN
   logic [31:0] instret;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: PC, IR, phase flag and retired count.
   logic [31:0] m_pc;
   logic [31:0] m_ir;
   bit          m_exec;
   logic [31:0] m_instret;

   if_stage #(
      .RESET_PC (RESET_PC),
      .BUBBLE_OP(BUBBLE_OP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .MIO_ready (MIO_ready),
      .inst_in   (inst_in),
      .Jump      (Jump),
      .Branch    (Branch),
      .zero      (zero),
      .PC_out    (PC_out),
      .inst_out  (inst_out),
      .OPcode    (OPcode),
      .Fun       (Fun),
      .inst_valid(inst_valid)
`ifdef IF_INSTRET_EN
      ,
      .instret   (instret)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ir,
                                            input bit j, input bit b, input bit z);
      logic [31:0] seq;
      logic [31:0] tgt;
      logic [31:0] offs;
      seq  = pc + 32'd4;
      tgt  = 32'(ir[25:0]);
      offs = 32'(signed'(ir[15:0]));
      if (j)           return (seq & 32'hF000_0000) + tgt * 32'd4;
      else if (b && z) return seq + offs * 32'd4;
      else             return seq;
   endfunction

   // One clock: model follows the edge, outputs compared on the following falling edge.
   task automatic cycle();
      @(posedge clk);
      if (rst) begin
         m_exec    = 1'b0;
         m_pc      = RESET_PC & 32'hFFFF_FFFC;
         m_ir      = '0;
         m_instret = '0;
      end else if (!m_exec) begin
         if (MIO_ready) begin
            m_ir   = inst_in;
            m_exec = 1'b1;
         end
      end else begin
         m_pc      = ref_next(m_pc, m_ir, Jump, Branch, zero);
         m_exec    = 1'b0;
         m_instret = m_instret + 32'd1;
      end
      @(negedge clk);
      check("pc",        PC_out, m_pc);
      check("inst_out",  inst_out, m_exec ? m_ir : m_ir);
      check("opcode",    32'(OPcode), m_exec ? 32'(m_ir >> 26) : 32'(BUBBLE_OP));
      check("fun",       32'(Fun), m_exec ? (m_ir & 32'h3F) : 32'h0);
      check("valid",     32'(inst_valid), 32'(m_exec));
`ifdef IF_INSTRET_EN
      check("instret",   instret, m_instret);
`endif
   endtask

   task automatic fetch(input logic [31:0] ir);
      rst       = 1'b0;
      MIO_ready = 1'b1;
      inst_in   = ir;
      Jump      = 1'($urandom);
      Branch    = 1'($urandom);
      zero      = 1'($urandom);
      cycle();
   endtask

   task automatic exec(input bit j, input bit b, input bit z);
      rst       = 1'b0;
      MIO_ready = 1'($urandom);
      inst_in   = $urandom;
      Jump      = j;
      Branch    = b;
      zero      = z;
      cycle();
   endtask

   initial begin
      rst = 1'b1; MIO_ready = 1'b1; inst_in = $urandom;
      Jump = 1'b1; Branch = 1'b1; zero = 1'b1;
      m_pc = '0; m_ir = '0; m_exec = 1'b0; m_instret = '0;

      // Reset held for two cycles.
      cycle();
      cycle();
      check("rst_pc",     PC_out, 32'h0);
      check("rst_op",     32'(OPcode), 32'h3F);
      check("rst_fun",    32'(Fun), 32'h0);
      check("rst_valid",  32'(inst_valid), 32'h0);
      check("rst_ir",     inst_out, 32'h0);

      // Sequential add at PC 0.
      fetch(32'h0022_1820);
      check("add_op",     32'(OPcode), 32'h0);
      check("add_fun",    32'(Fun), 32'h20);
      check("add_valid",  32'(inst_valid), 32'h1);
      exec(1'b0, 1'b0, 1'b0);
      check("add_pc",     PC_out, 32'h4);
      check("add_fetch",  32'(inst_valid), 32'h0);

      // Jump to 0x10, then the branch cases from there.
      fetch(32'h0800_0004); exec(1'b1, 1'b0, 1'b0);
      check("j10_pc",     PC_out, 32'h10);
      fetch(32'h1000_0003); exec(1'b0, 1'b1, 1'b1);
      check("beq_taken",  PC_out, 32'h20);
      fetch(32'h0800_0004); exec(1'b1, 1'b0, 1'b0);
      fetch(32'h1000_0003); exec(1'b0, 1'b1, 1'b0);
      check("beq_not",    PC_out, 32'h14);
      fetch(32'h0800_0004); exec(1'b1, 1'b0, 1'b0);
      fetch(32'h1000_FFFF); exec(1'b0, 1'b1, 1'b1);
      check("beq_self",   PC_out, 32'h10);
      fetch(32'h0800_0040); exec(1'b1, 1'b1, 1'b1);
      check("jump_wins",  PC_out, 32'h100);

      // Memory wait: three FETCH cycles with MIO_ready low.
      for (int i = 0; i < 3; i++) begin
         rst = 1'b0; MIO_ready = 1'b0; inst_in = $urandom;
         Jump = 1'($urandom); Branch = 1'($urandom); zero = 1'($urandom);
         cycle();
         check("wait_pc",    PC_out, 32'h100);
         check("wait_op",    32'(OPcode), 32'h3F);
         check("wait_valid", 32'(inst_valid), 32'h0);
      end
      fetch(32'h2108_0005);
      check("wait_exec",  32'(inst_valid), 32'h1);
      exec(1'b0, 1'b0, 1'b0);
      check("wait_pc4",   PC_out, 32'h104);

      // Reset while in EXEC at PC 0x40.
      fetch(32'h0800_0010); exec(1'b1, 1'b0, 1'b0);
      check("j40_pc",     PC_out, 32'h40);
      fetch(32'h0800_0020);
      rst = 1'b1; Jump = 1'b1; Branch = 1'b0; zero = 1'b0; MIO_ready = 1'b1;
      cycle();
      check("rexec_pc",   PC_out, 32'h0);
      check("rexec_vld",  32'(inst_valid), 32'h0);
`ifdef IF_INSTRET_EN
      check("rexec_cnt",  instret, 32'h0);
`endif
      for (int i = 0; i < 5; i++) begin
         fetch($urandom); exec(1'b0, 1'b0, 1'b0);
      end
      check("five_pc",    PC_out, 32'h14);
`ifdef IF_INSTRET_EN
      check("five_cnt",   instret, 32'h5);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 40) == 0);
         MIO_ready = ($urandom_range(0, 3) != 0);
         inst_in   = $urandom;
         Jump      = ($urandom_range(0, 3) == 0);
         Branch    = 1'($urandom);
         zero      = 1'($urandom);
         cycle();
         check("pc_align", PC_out & 32'h3, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
